piso_frame_serializer: RTL and testbench
========================================

Name: piso_frame_serializer

Overview:
- Upstream stage of the serial-in/parallel-out shift register.
- Accepts a parallel word over a valid/ready handshake and serializes it onto SI, one bit per Clock.
- After the last bit it issues a single-cycle latch strobe so the downstream register captures the frame.
- Enforces a programmable idle gap between frames, then accepts the next word.

Parameters:
- WIDTH, 8: frame width in bits; must match the downstream shift register depth; legal range 2..32.
- LSB_FIRST, 0: 0 = MSB transmitted first, 1 = LSB transmitted first.
- GAP_CYCLES, 1: idle cycles after the latch strobe before din_ready re-asserts; legal range 0..15.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- SI  output  1  serial data to the downstream shift register; registered.
- latch  output  1  one-cycle capture strobe to the downstream register; registered.
- busy  output  1  high in every state except IDLE.
- bit_idx  output  5  index of the bit currently on SI (0 = first bit sent); 0 outside SHIFT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, SI=0, latch=0, din_ready=0, busy=0, bit_idx=0, shift register cleared, counters cleared.
- din_ready becomes 1 on the first rising edge after rst releases.
- States: IDLE, SHIFT, LATCH, GAP.
- IDLE:
  - din_ready=1, SI=0, latch=0.
  - On a rising edge with din_valid=1 and din_ready=1 (accept edge E): load din into the shift register, go to SHIFT, drive din_ready=0.
  - din_valid while din_ready=0 is ignored; the word is not captured.
- SHIFT:
  - Lasts exactly WIDTH cycles.
  - In cycle E+1+i (i=0..WIDTH-1), SI = din[WIDTH-1-i] when LSB_FIRST=0, or din[i] when LSB_FIRST=1; bit_idx = i.
  - The downstream register samples SI on the edge ending each cycle.
  - din changes after E have no effect on the frame in flight.
- LATCH:
  - One cycle at E+WIDTH+1: latch=1, SI=0, bit_idx=0.
  - latch is never high in any other state.
- GAP:
  - GAP_CYCLES cycles with SI=0, latch=0, busy=1, din_ready=0.
  - Then IDLE; din_ready=1 in the next cycle.
  - If GAP_CYCLES=0, LATCH goes directly to IDLE.
- Throughput: one frame per WIDTH+2+GAP_CYCLES cycles with back-to-back din_valid.
- Latency: first bit on SI one cycle after the accept edge; latch WIDTH+1 cycles after the accept edge.
- Counters:
  - Bit counter is 5 bits and counts 0..WIDTH-1 with no wrap.
  - Gap counter is 4 bits and counts 0..GAP_CYCLES-1.
  - The terminal count triggers the transition; no modular wrap-around.
- Reset mid-operation: the frame is aborted immediately. No latch pulse is emitted, and no partial latch is issued after reset releases.
- Simultaneous events: din_valid rising in the same cycle as the LATCH→IDLE transition is not accepted until din_ready is high (the following edge).

Test Plan (WIDTH=8, LSB_FIRST=0, GAP_CYCLES=1 unless noted):
- Reset with rst=0 for 2 cycles, then release → SI=0, latch=0, busy=0 during reset; din_ready=1 one edge after release.
- din=8'hB5, din_valid pulse accepted at edge E → SI over cycles E+1..E+8 = 1,0,1,1,0,1,0,1; latch=1 only in cycle E+9; din_ready=1 again in cycle E+11.
- LSB_FIRST=1, din=8'hB5 → SI sequence 1,0,1,0,1,1,0,1; latch at E+9.
- din_valid held high with words 8'h3C then 8'hC3 → exactly two frames, accept edges 11 cycles apart; the second frame is sent as 0,0,1,1,1,1,0,0 → 1,1,0,0,0,0,1,1; din toggled during SHIFT does not corrupt SI.
- rst pulsed low during SHIFT at bit_idx=4 → SI=0 and busy=0 immediately; no latch pulse for 12 cycles after release; the next word transmits correctly.
- GAP_CYCLES=0, back-to-back 8'hFF, 8'h00 → accept edges 10 cycles apart; latch pulses exactly one cycle wide, 10 cycles apart.

Source files
------------

// File: rtl/piso_frame_serializer_if.sv
// Parallel-word handshake into the serializer plus the serial link toward the
// downstream shift register.
interface piso_frame_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             SI;
  logic             latch;
  logic             busy;
  logic [4:0]       bit_idx;

  modport master (
    output din, din_valid,
    input  din_ready, SI, latch, busy, bit_idx
  );

  modport slave (
    input  din, din_valid,
    output din_ready, SI, latch, busy, bit_idx
  );
endinterface

// File: rtl/piso_frame_serializer.sv
// Serializes one parallel word per frame onto SI, then pulses latch and
// holds off for a programmable idle gap before taking the next word.
module piso_frame_serializer #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    Clock,
  input  logic                    rst,
  piso_frame_serializer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  localparam logic [4:0] BIT_LAST = 5'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg_p0, sreg_nxt;
  logic [4:0]       bit_cnt_p0, bit_cnt_nxt;
  logic [3:0]       gap_cnt_p0, gap_cnt_nxt;
  logic             si_p0, si_nxt;
  logic             latch_p0;
  logic             rdy_p0;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign accept = (state == IDLE) && rdy_p0 && bus.din_valid;

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg_p0;
    bit_cnt_nxt = '0;
    gap_cnt_nxt = '0;
    si_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = bus.din;
          si_nxt    = first_bit(bus.din);
        end
      end
      SHIFT: begin
        // sreg always holds the word whose leading bit is currently on SI
        if (bit_cnt_p0 == BIT_LAST) begin
          state_nxt = LATCH;
        end else begin
          bit_cnt_nxt = bit_cnt_p0 + 5'd1;
          sreg_nxt    = advance(sreg_p0);
          si_nxt      = first_bit(advance(sreg_p0));
        end
      end
      LATCH: begin
        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_p0 == GAP_LAST) state_nxt = IDLE;
        else                        gap_cnt_nxt = gap_cnt_p0 + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: all outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sreg_p0    <= '0;
      bit_cnt_p0 <= '0;
      gap_cnt_p0 <= '0;
      si_p0      <= 1'b0;
      latch_p0   <= 1'b0;
      rdy_p0     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg_p0    <= sreg_nxt;
      bit_cnt_p0 <= bit_cnt_nxt;
      gap_cnt_p0 <= gap_cnt_nxt;
      si_p0      <= si_nxt;
      latch_p0   <= (state_nxt == LATCH);
      rdy_p0     <= (state_nxt == IDLE);
    end
  end

  assign bus.din_ready = rdy_p0;
  assign bus.SI        = si_p0;
  assign bus.latch     = latch_p0;
  assign bus.busy      = (state != IDLE);
  assign bus.bit_idx   = (state == SHIFT) ? bit_cnt_p0 : 5'd0;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: MSB-first/gap 1, LSB-first/gap 1
// and MSB-first/gap 0 instances share one clock and reset.
module tb_piso_frame_serializer;

  localparam int F_IDX  = 0;
  localparam int F_BUSY = 1;
  localparam int F_LAT  = 2;
  localparam int F_SI   = 3;
  localparam int F_RDY  = 4;

  logic Clock = 1'b0;
  logic rst   = 1'b0;
  always #5 Clock = ~Clock;

  piso_frame_serializer_if #(.WIDTH(8)) ifm ();
  piso_frame_serializer_if #(.WIDTH(8)) ifl ();
  piso_frame_serializer_if #(.WIDTH(8)) ifg ();

  piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(1)) u_msb (
    .Clock(Clock), .rst(rst), .bus(ifm.slave));
  piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP_CYCLES(1)) u_lsb (
    .Clock(Clock), .rst(rst), .bus(ifl.slave));
  piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) u_g0 (
    .Clock(Clock), .rst(rst), .bus(ifg.slave));

  logic [7:0] din_d [3];
  logic       vld_d [3];
  logic [8:0] o     [3];

  assign ifm.din = din_d[0];  assign ifm.din_valid = vld_d[0];
  assign ifl.din = din_d[1];  assign ifl.din_valid = vld_d[1];
  assign ifg.din = din_d[2];  assign ifg.din_valid = vld_d[2];

  assign o[0] = {ifm.din_ready, ifm.SI, ifm.latch, ifm.busy, ifm.bit_idx};
  assign o[1] = {ifl.din_ready, ifl.SI, ifl.latch, ifl.busy, ifl.bit_idx};
  assign o[2] = {ifg.din_ready, ifg.SI, ifg.latch, ifg.busy, ifg.bit_idx};

  int n_cmp = 0;
  int n_bad = 0;

  // Edge-accurate event log: accept edges and latch-high edges per instance
  int cyc = 0;
  int acc_n [3];
  int lat_n [3];
  int acc_c [3][8];
  int lat_c [3][8];

  always @(posedge Clock) begin
    cyc = cyc + 1;
    for (int s = 0; s < 3; s++) begin
      if (vld_d[s] === 1'b1 && o[s][8] === 1'b1) begin
        if (acc_n[s] < 8) acc_c[s][acc_n[s]] = cyc;
        acc_n[s] = acc_n[s] + 1;
      end
      if (o[s][6] === 1'b1) begin
        if (lat_n[s] < 8) lat_c[s][lat_n[s]] = cyc;
        lat_n[s] = lat_n[s] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int s, input int f);
    logic [8:0] v;
    v = o[s];
    case (f)
      F_IDX:   return {27'd0, v[4:0]};
      F_BUSY:  return {31'd0, v[5]};
      F_LAT:   return {31'd0, v[6]};
      F_SI:    return {31'd0, v[7]};
      default: return {31'd0, v[8]};
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Sends one word on instance s; seq lists the expected SI bits, first bit in seq[7].
  // Called in a cycle with din_ready high; returns in the next din_ready-high cycle.
  task automatic frame(input int s, input string nm, input logic [7:0] word,
                       input logic [7:0] seq, input int gap, input logic keep_valid,
                       input logic [7:0] next_word);
    check($sformatf("%s rdy_pre", nm), sig(s, F_RDY), 32'd1);
    din_d[s] = word;
    vld_d[s] = 1'b1;
    tick();
    vld_d[s] = keep_valid;
    din_d[s] = ~word;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s si%0d", nm, i),  sig(s, F_SI),   {31'd0, seq[7-i]});
      check($sformatf("%s idx%0d", nm, i), sig(s, F_IDX),  32'(i));
      check($sformatf("%s lat%0d", nm, i), sig(s, F_LAT),  32'd0);
      check($sformatf("%s bsy%0d", nm, i), sig(s, F_BUSY), 32'd1);
      check($sformatf("%s rdy%0d", nm, i), sig(s, F_RDY),  32'd0);
      din_d[s] = din_d[s] ^ 8'h5A;
      tick();
    end
    din_d[s] = next_word;
    check($sformatf("%s latch", nm),     sig(s, F_LAT),  32'd1);
    check($sformatf("%s latch_si", nm),  sig(s, F_SI),   32'd0);
    check($sformatf("%s latch_idx", nm), sig(s, F_IDX),  32'd0);
    check($sformatf("%s latch_rdy", nm), sig(s, F_RDY),  32'd0);
    check($sformatf("%s latch_bsy", nm), sig(s, F_BUSY), 32'd1);
    tick();
    for (int g = 0; g < gap; g++) begin
      check($sformatf("%s gap_lat%0d", nm, g), sig(s, F_LAT),  32'd0);
      check($sformatf("%s gap_rdy%0d", nm, g), sig(s, F_RDY),  32'd0);
      check($sformatf("%s gap_bsy%0d", nm, g), sig(s, F_BUSY), 32'd1);
      check($sformatf("%s gap_si%0d", nm, g),  sig(s, F_SI),   32'd0);
      tick();
    end
    check($sformatf("%s end_rdy", nm), sig(s, F_RDY),  32'd1);
    check($sformatf("%s end_bsy", nm), sig(s, F_BUSY), 32'd0);
    check($sformatf("%s end_lat", nm), sig(s, F_LAT),  32'd0);
  endtask

  int base;
  int lbase;

  initial begin
    for (int s = 0; s < 3; s++) begin
      din_d[s] = 8'h00;
      vld_d[s] = 1'b0;
      acc_n[s] = 0;
      lat_n[s] = 0;
    end

    // Reset held for two edges
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int s = 0; s < 3; s++) begin
        check($sformatf("rst si u%0d", s),  sig(s, F_SI),   32'd0);
        check($sformatf("rst lat u%0d", s), sig(s, F_LAT),  32'd0);
        check($sformatf("rst bsy u%0d", s), sig(s, F_BUSY), 32'd0);
        check($sformatf("rst rdy u%0d", s), sig(s, F_RDY),  32'd0);
        check($sformatf("rst idx u%0d", s), sig(s, F_IDX),  32'd0);
      end
    end
    rst = 1'b1;
    #1;
    check("rel rdy before edge", sig(0, F_RDY), 32'd0);
    tick();
    for (int s = 0; s < 3; s++)
      check($sformatf("rel rdy u%0d", s), sig(s, F_RDY), 32'd1);

    // MSB first, 8'hB5
    frame(0, "msb_b5", 8'hB5, 8'hB5, 1, 1'b0, 8'h00);
    check("msb_b5 accepts", acc_n[0], 32'd1);
    check("msb_b5 latch lat", lat_c[0][0] - acc_c[0][0], 32'd9);

    // LSB first, 8'hB5 -> 1,0,1,0,1,1,0,1
    frame(1, "lsb_b5", 8'hB5, 8'hAD, 1, 1'b0, 8'h00);
    check("lsb_b5 accepts", acc_n[1], 32'd1);
    check("lsb_b5 latch lat", lat_c[1][0] - acc_c[1][0], 32'd9);

    // din_valid held high across two words
    base  = acc_n[0];
    lbase = lat_n[0];
    frame(0, "b2b_3c", 8'h3C, 8'h3C, 1, 1'b1, 8'hC3);
    frame(0, "b2b_c3", 8'hC3, 8'hC3, 1, 1'b0, 8'h00);
    tick();
    tick();
    check("b2b accepts", acc_n[0] - base, 32'd2);
    check("b2b spacing", acc_c[0][base+1] - acc_c[0][base], 32'd11);
    check("b2b latches", lat_n[0] - lbase, 32'd2);

    // Reset asserted mid-frame at bit_idx 4
    check("abort rdy_pre", sig(0, F_RDY), 32'd1);
    din_d[0] = 8'hA5;
    vld_d[0] = 1'b1;
    tick();
    vld_d[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("abort idx4", sig(0, F_IDX),  32'd4);
    check("abort bsy",  sig(0, F_BUSY), 32'd1);
    lbase = lat_n[0];
    rst = 1'b0;
    #1;
    check("abort si",  sig(0, F_SI),   32'd0);
    check("abort bsy0", sig(0, F_BUSY), 32'd0);
    check("abort lat", sig(0, F_LAT),  32'd0);
    check("abort rdy", sig(0, F_RDY),  32'd0);
    check("abort idx", sig(0, F_IDX),  32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("abort no latch", lat_n[0] - lbase, 32'd0);
    frame(0, "post_96", 8'h96, 8'h96, 1, 1'b0, 8'h00);

    // Zero gap, back-to-back 8'hFF then 8'h00
    base  = acc_n[2];
    lbase = lat_n[2];
    frame(2, "g0_ff", 8'hFF, 8'hFF, 0, 1'b1, 8'h00);
    frame(2, "g0_00", 8'h00, 8'h00, 0, 1'b0, 8'h00);
    tick();
    tick();
    check("g0 accepts", acc_n[2] - base, 32'd2);
    check("g0 acc spacing", acc_c[2][base+1] - acc_c[2][base], 32'd10);
    check("g0 latch cycles", lat_n[2] - lbase, 32'd2);
    check("g0 latch spacing", lat_c[2][lbase+1] - lat_c[2][lbase], 32'd10);

    // Totals over the whole run
    check("tot acc msb", acc_n[0], 32'd5);
    check("tot lat msb", lat_n[0], 32'd4);
    check("tot acc lsb", acc_n[1], 32'd1);
    check("tot lat lsb", lat_n[1], 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
